// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_SAT_EN to clamp diff to zero on final borrow-out.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] a_r, b_r, res, res_nx;
   logic [CW-1:0]    cnt;
   logic             br, br_nx;
   logic             ai, bi, d;
   logic             last, load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // One full-subtractor cell, fed by the bit selected by the counter.
   always_comb begin
      ai          = a_r[cnt];
      bi          = b_r[cnt];
      d           = ai ^ bi ^ br;
      br_nx       = (~ai & bi) | (~(ai ^ bi) & br);
      last        = (cnt == LAST);
      res_nx      = res;
      res_nx[cnt] = d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r  <= '0;
         b_r  <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else if (load) begin
         a_r <= a;
         b_r <= b;
         br  <= bin;
         cnt <= '0;
      end else if (state == RUN) begin
         res <= res_nx;
         br  <= br_nx;
         cnt <= cnt + CW'(1);
         // Outputs change only once the last bit is known.
         if (last) begin
            bout <= br_nx;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
            diff <= br_nx ? '0 : res_nx;
`else
            diff <= res_nx;
`endif
         end
      end
   end

endmodule
